// File: rtl/c432_wrapper_if.sv
// c432_wrapper_if: bundles the 36-bit request/enable vector (in_vec) and the 7-bit registered result (out_vec)
interface c432_wrapper_if;
  logic [35:0] in_vec;
  logic [6:0]  out_vec;
  modport master (output in_vec, input out_vec);
  modport slave (input in_vec, output out_vec);
endinterface

// File: rtl/c432_wrapper.sv
// c432_wrapper: registered 27-channel 3-bus priority interrupt core; ports clk, rst_n (sync active-low), bus.in_vec {E,C,B,A} -> bus.out_vec {PA,PB,PC,CHAN}
module c432_wrapper (
  input logic             clk,
  input logic             rst_n,
  c432_wrapper_if.slave   bus
);
  logic [35:0] in_q;
  logic [6:0]  out_q, out_d;
  logic [8:0]  ra, rb, rc, w;
  logic        pa, pb, pc;
  logic [3:0]  chan;
  assign ra = in_q[8:0] & in_q[35:27];
  assign rb = in_q[17:9] & in_q[35:27];
  assign rc = in_q[26:18] & in_q[35:27];
  assign pa = |ra;
  assign pb = ~pa & |rb;
  assign pc = ~pa & ~pb & |rc;
  assign w = pa ? ra : pb ? rb : pc ? rc : 9'h000;
  always_comb begin
    chan = 4'hF;
    for (int i = 8; i >= 0; i--)
      if (w[i]) chan = 4'(i);
  end
  assign out_d = {pa, pb, pc, chan};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= bus.in_vec;
      out_q <= out_d;
    end
  end
  assign bus.out_vec = out_q;
endmodule

// File: tb/tb_c432_wrapper.sv
// tb_c432_wrapper: table-driven, reset-sequence and randomized model checks for c432_wrapper
module tb_c432_wrapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int bit_err [7];
  c432_wrapper_if bus ();
  c432_wrapper u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [35:0] vin;
    logic [6:0]  exp;
    string       name;
  } vec_t;
  vec_t tbl [7];
  function automatic logic [6:0] ref_out(input logic [35:0] v);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 9; i++)
        if (v[9*b+i] && v[27+i])
          return {3'(3'b100 >> b), 4'(i)};
    return 7'b000_1111;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  initial begin
    logic [35:0] v;
    logic [6:0] e;
    logic [6:0] q [$];
    tbl[0] = '{{9'h010, 9'h1FF, 9'h1FF, 9'h1FF}, 7'b100_0100, "bus_a_priority"};
    tbl[1] = '{{9'h004, 9'h000, 9'h004, 9'h001}, 7'b010_0010, "enable_masking"};
    tbl[2] = '{{9'h1FF, 9'h180, 9'h000, 9'h000}, 7'b001_0111, "bus_c_in_bus"};
    tbl[3] = '{{9'h000, 9'h1FF, 9'h1FF, 9'h1FF}, 7'b000_1111, "no_request"};
    tbl[4] = '{{9'h100, 9'h000, 9'h000, 9'h100}, 7'b100_1000, "a_chan8"};
    tbl[5] = '{{9'h1FF, 9'h000, 9'h001, 9'h000}, 7'b010_0000, "b_chan0"};
    tbl[6] = '{{9'h001, 9'h001, 9'h000, 9'h002}, 7'b001_0000, "c_chan0_a_masked"};
    foreach (bit_err[i]) bit_err[i] = 0;
    bus.in_vec = {$urandom, $urandom};
    tick();
    check("reset_hold_1", bus.out_vec, 7'h00);
    bus.in_vec = {$urandom, $urandom};
    tick();
    check("reset_hold_2", bus.out_vec, 7'h00);
    rst_n = 1'b1;
    bus.in_vec = tbl[0].vin;
    tick();
    check("post_reset_idle", bus.out_vec, 7'b000_1111);
    tick();
    check("post_reset_first", bus.out_vec, tbl[0].exp);
    for (int k = 0; k < 7; k++) begin
      bus.in_vec = tbl[k].vin;
      tick();
      tick();
      check(tbl[k].name, bus.out_vec, tbl[k].exp);
    end
    bus.in_vec = tbl[4].vin;
    tick();
    rst_n = 1'b0;
    bus.in_vec = tbl[5].vin;
    tick();
    check("midstream_reset", bus.out_vec, 7'h00);
    rst_n = 1'b1;
    bus.in_vec = tbl[1].vin;
    tick();
    check("midstream_idle", bus.out_vec, 7'b000_1111);
    bus.in_vec = tbl[2].vin;
    tick();
    check("midstream_first", bus.out_vec, tbl[1].exp);
    tick();
    check("midstream_second", bus.out_vec, tbl[2].exp);
    for (int k = 0; k < 20000; k++) begin
      v = {$urandom, $urandom};
      case (k % 4)
        0: v[35:27] = v[35:27] & 9'($urandom) & 9'($urandom);
        1: v[8:0] = v[8:0] & 9'($urandom) & 9'($urandom) & 9'($urandom);
        2: v[17:0] = v[17:0] & 18'($urandom) & 18'($urandom) & 18'($urandom);
        default: ;
      endcase
      bus.in_vec = v;
      tick();
      q.push_back(ref_out(v));
      if (q.size() == 2) begin
        e = q.pop_front();
        for (int b = 0; b < 7; b++)
          if (bus.out_vec[b] !== e[b]) bit_err[b]++;
        check("random_stream", bus.out_vec, e);
      end
    end
    $display("per-bit mismatch counts PA=%0d PB=%0d PC=%0d CHAN3=%0d CHAN2=%0d CHAN1=%0d CHAN0=%0d",
             bit_err[6], bit_err[5], bit_err[4], bit_err[3], bit_err[2], bit_err[1], bit_err[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
